// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target backed by an internal word RAM.
// The response appears 1+WAIT_CYCLES edges after accept; RAM contents survive reset.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clkin,
    input  logic        nrst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic [3:0]  req_wstrb_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_err_out
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // 33 bits so that BASE_ADDR plus the RAM size cannot wrap past 2^32.
    localparam logic [32:0] LIMIT_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic          r_rd_sel;
    logic [31:0]   r_ram_rdata;
    logic [31:0]   r_ram [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign req_ready_out = nrst_in && (r_state == StIdle);
    assign w_accept      = req_valid_in && req_ready_out;

    // The commit edge follows the edge on which the wait counter has reached zero.
    assign w_commit = nrst_in && (r_state == StWait) && (r_cnt == 4'd0);

    assign w_err = (r_addr[1:0] != 2'b00) || (r_addr < BASE_ADDR) || ({1'b0, r_addr} >= LIMIT_ADDR);
    assign w_idx = AW'((r_addr - BASE_ADDR) >> 2);

    // Single-port, read-first RAM with byte write enables.
    always_ff @(posedge clkin) begin
        if (w_commit && !w_err) begin
            if (r_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (r_wstrb[i]) begin
                        r_ram[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                    end
                end
            end
            r_ram_rdata <= r_ram[w_idx];
        end
    end

    always_ff @(posedge clkin) begin
        if (!nrst_in) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_sel    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_we    <= req_we_in;
                        r_addr  <= req_addr_in;
                        r_wdata <= req_wdata_in;
                        r_wstrb <= req_wstrb_in;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rd_sel    <= !w_err && !r_we;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready_in) begin
                        r_state     <= StIdle;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rd_sel    <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rsp_valid_out = r_rsp_valid;
    assign rsp_err_out   = r_rsp_err;
    assign rsp_rdata_out = r_rd_sel ? r_ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked against a word-array model.
module tb_dmem_responder;
    logic        clk;
    logic        nrst;
    logic [2:0]  rv;
    logic [2:0]  rr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  err;
    logic [31:0] rdata [3];

    int          vectors;
    int          miscompares;
    int          wc [3] = '{1, 0, 3};
    logic [31:0] mdl [3][1024];

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
        .clkin(clk), .nrst_in(nrst), .req_valid_in(rv[0]), .req_ready_out(rdy[0]),
        .req_we_in(we), .req_addr_in(addr), .req_wdata_in(wdata), .req_wstrb_in(wstrb),
        .rsp_valid_out(vld[0]), .rsp_ready_in(rr[0]), .rsp_rdata_out(rdata[0]),
        .rsp_err_out(err[0])
    );
    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
        .clkin(clk), .nrst_in(nrst), .req_valid_in(rv[1]), .req_ready_out(rdy[1]),
        .req_we_in(we), .req_addr_in(addr), .req_wdata_in(wdata), .req_wstrb_in(wstrb),
        .rsp_valid_out(vld[1]), .rsp_ready_in(rr[1]), .rsp_rdata_out(rdata[1]),
        .rsp_err_out(err[1])
    );
    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
        .clkin(clk), .nrst_in(nrst), .req_valid_in(rv[2]), .req_ready_out(rdy[2]),
        .req_we_in(we), .req_addr_in(addr), .req_wdata_in(wdata), .req_wstrb_in(wstrb),
        .rsp_valid_out(vld[2]), .rsp_ready_in(rr[2]), .rsp_rdata_out(rdata[2]),
        .rsp_err_out(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    function automatic bit exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h1000);
    endfunction

    function automatic logic [31:0] exp_load(input int d, input logic [31:0] a);
        return exp_err(a) ? 32'h0 : mdl[d][a[11:2]];
    endfunction

    task automatic mdl_store(input int d, input logic [31:0] a, input logic [31:0] dat,
                             input logic [3:0] s);
        if (!exp_err(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) mdl[d][a[11:2]][8*i +: 8] = dat[8*i +: 8];
            end
        end
    endtask

    // Drive one request until accepted, scramble inputs, then wait for the response.
    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                         input logic [3:0] s, output int lat, output logic [31:0] o_rd,
                         output logic o_err, output bit o_to);
        int n;
        o_to  = 1'b0;
        we    = w;
        addr  = a;
        wdata = dat;
        wstrb = s;
        rv[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) o_to = 1'b1;
        @(posedge clk); #1;
        rv[d] = 1'b0;
        we    = ~w;
        addr  = $urandom;
        wdata = $urandom;
        wstrb = 4'($urandom);
        lat = 0;
        while (!vld[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) o_to = 1'b1;
        o_rd  = rdata[d];
        o_err = err[d];
    endtask

    task automatic complete(input int d);
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        rv = '0;
        rr = '0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (rdy[d] !== 1'b0 || vld[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b vld=%b rd=%h err=%b, required 0 0 0 0",
                         d, rdy[d], vld[d], rdata[d], err[d]);
            end
        end
        nrst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (rdy[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_release_ready[%0d]: got %b, required 1", d, rdy[d]);
            end
        end
    endtask

    // Directed transaction with full latency/data/error checking against the model.
    task automatic txn_check(input string name, input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] dat, input logic [3:0] s);
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          to;
        logic [31:0] exp_rd;
        exp_rd = w ? 32'h0 : exp_load(d, a);
        issue(d, w, a, dat, s, lat, rd, e, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s timeout: got no handshake, required response", name);
        end
        vectors++;
        if (lat != 1 + wc[d]) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, 1 + wc[d]);
        end
        vectors++;
        if (e !== exp_err(a)) begin
            miscompares++;
            $display("FAIL %s err: got %b, required %b", name, e, exp_err(a));
        end
        vectors++;
        if (rd !== exp_rd) begin
            miscompares++;
            $display("FAIL %s rdata: got %h, required %h", name, rd, exp_rd);
        end
        complete(d);
        if (w) mdl_store(d, a, dat, s);
    endtask

    task automatic test_store_load;
        txn_check("store_10", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        txn_check("load_10", 0, 1'b0, 32'h10, 32'h0, 4'hF);
        vectors++;
        if (mdl[0][4] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL model_10: got %h, required deadbeef", mdl[0][4]);
        end
    endtask

    task automatic test_byte_merge;
        txn_check("merge_full", 0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        txn_check("merge_part", 0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        txn_check("merge_load", 0, 1'b0, 32'h20, 32'h0, 4'h0);
    endtask

    task automatic test_backpressure;
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          to;
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, e, to);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (vld[0] !== 1'b1 || rdata[0] !== 32'h11BB_33DD || err[0] !== 1'b0 || rdy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rd=%h err=%b rdy=%b, required 1 11bb33dd 0 0",
                         i, vld[0], rdata[0], err[0], rdy[0]);
            end
        end
        complete(0);
        vectors++;
        if (vld[0] !== 1'b0 || rdata[0] !== 32'h0 || rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: got vld=%b rd=%h rdy=%b, required 0 0 1",
                     vld[0], rdata[0], rdy[0]);
        end
    endtask

    task automatic test_errors;
        txn_check("err_prefill0", 0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF);
        txn_check("err_misalign", 0, 1'b0, 32'h13, 32'h0, 4'hF);
        txn_check("err_range", 0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        txn_check("err_word0", 0, 1'b0, 32'h0, 32'h0, 4'hF);
        txn_check("err_top", 0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
        txn_check("zero_strb", 0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
        txn_check("zero_strb_load", 0, 1'b0, 32'h20, 32'h0, 4'h0);
    endtask

    task automatic test_latency;
        txn_check("lat0_store", 1, 1'b1, 32'h80, 32'h5A5A_0F0F, 4'hF);
        txn_check("lat0_load", 1, 1'b0, 32'h80, 32'h0, 4'hF);
        txn_check("lat3_store", 2, 1'b1, 32'h80, 32'hA5A5_F0F0, 4'hF);
        txn_check("lat3_load", 2, 1'b0, 32'h80, 32'h0, 4'hF);
    endtask

    task automatic test_mid_reset;
        int n;
        txn_check("mr_prefill", 2, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
        we    = 1'b1;
        addr  = 32'h40;
        wdata = 32'h1234_5678;
        wstrb = 4'hF;
        rv[2] = 1'b1;
        n = 0;
        while (!rdy[2] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rv[2] = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (rdy[2] !== 1'b0 || vld[2] !== 1'b0 || rdata[2] !== 32'h0 || err[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got rdy=%b vld=%b rd=%h err=%b, required 0 0 0 0",
                     rdy[2], vld[2], rdata[2], err[2]);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        #1;
        vectors++;
        if (rdy[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_ready: got %b, required 1", rdy[2]);
        end
        txn_check("mr_load", 2, 1'b0, 32'h40, 32'h0, 4'hF);
    endtask

    task automatic test_random(input int d);
        logic [31:0] a;
        logic [31:0] dat;
        logic [3:0]  s;
        logic        w;
        int          kind;
        int          wi;
        int          hold;
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          to;
        logic [31:0] exp_rd;
        for (int i = 0; i < 16; i++) begin
            txn_check("rnd_fill", d, 1'b1, 32'(i * 4 + 256), $urandom, 4'hF);
        end
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 9);
            wi   = $urandom_range(0, 15);
            if (kind == 0)      a = 32'(wi * 4 + 256 + $urandom_range(1, 3));
            else if (kind == 1) a = 32'(32'h1000 + wi * 4);
            else                a = 32'(wi * 4 + 256);
            w    = 1'($urandom_range(0, 1));
            dat  = $urandom;
            s    = 4'($urandom);
            hold = $urandom_range(0, 3);
            exp_rd = w ? 32'h0 : exp_load(d, a);
            issue(d, w, a, dat, s, lat, rd, e, to);
            vectors++;
            if (to || lat != 1 + wc[d]) begin
                miscompares++;
                $display("FAIL rnd[%0d] latency: got %0d (timeout=%0d), required %0d",
                         d, lat, to, 1 + wc[d]);
            end
            vectors++;
            if (e !== exp_err(a) || rd !== exp_rd) begin
                miscompares++;
                $display("FAIL rnd[%0d] data: addr=%h we=%b got rd=%h err=%b, required rd=%h err=%b",
                         d, a, w, rd, e, exp_rd, exp_err(a));
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                vectors++;
                if (vld[d] !== 1'b1 || rdata[d] !== exp_rd || rdy[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd[%0d] hold: got vld=%b rd=%h rdy=%b, required 1 %h 0",
                             d, vld[d], rdata[d], rdy[d], exp_rd);
                end
            end
            complete(d);
            if (w) mdl_store(d, a, dat, s);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_store_load();
        test_byte_merge();
        test_backpressure();
        test_errors();
        test_latency();
        test_mid_reset();
        for (int d = 0; d < 3; d++) test_random(d);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
